// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA request/priority arbiter.
package dma_priority_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // Bit positions of the arbitration controls within the DMA command register
    localparam int CMD_DISABLE   = 2;
    localparam int CMD_ROTATE    = 4;
    localparam int CMD_DREQ_LOW  = 6;
    localparam int CMD_DACK_HIGH = 7;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_SERVICE = 2'd2,
        ARB_RELEASE = 2'd3
    } arbState_t;

    function automatic logic [NUM_CH-1:0] onehot_f(input logic [CH_W-1:0] idx);
        onehot_f = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the arbiter (slave) and the register file plus
// timing FSM that drive it (master).
interface dma_priority_arbiter_if
    import dma_priority_arbiter_pkg::*;
();
    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] swReq;
    logic [NUM_CH-1:0] maskReg;
    logic              cmdDisable;
    logic              cmdRotate;
    logic              dreqSenseLow;
    logic              dackSenseHigh;
    logic              idleCycle;
    logic              hlda;
    logic              validDack;
    logic              serviceDone;
    logic [NUM_CH-1:0] VALID_DREQ;
    logic [CH_W-1:0]   activeCh;
    logic              reqPending;
    logic [NUM_CH-1:0] reqStatus;
    logic [NUM_CH-1:0] DACK;

    modport master (
        output DREQ, swReq, maskReg, cmdDisable, cmdRotate, dreqSenseLow,
               dackSenseHigh, idleCycle, hlda, validDack, serviceDone,
        input  VALID_DREQ, activeCh, reqPending, reqStatus, DACK
    );

    modport slave (
        input  DREQ, swReq, maskReg, cmdDisable, cmdRotate, dreqSenseLow,
               dackSenseHigh, idleCycle, hlda, validDack, serviceDone,
        output VALID_DREQ, activeCh, reqPending, reqStatus, DACK
    );
endinterface

// File: rtl/dma_priority_arbiter_priority_encoder.sv
// Rotating find-first: picks the requesting channel closest above low_pri_i (mod NUM_CH).
module dma_priority_encoder
    import dma_priority_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] eff_i,
    input  logic [CH_W-1:0]   low_pri_i,
    output logic [CH_W-1:0]   winner_o,
    output logic              valid_o
);
    logic [CH_W-1:0] idx_s;

    // Scan from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx_s    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx_s    = low_pri_i + CH_W'(i + 1);
            valid_o  = valid_o | eff_i[idx_s];
            winner_o = eff_i[idx_s] ? idx_s : winner_o;
        end
    end
endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA request sampling, masking and fixed/rotating priority arbitration.
// Optional build macro DMA_DREQ_SYNC_EN adds a 2-flop DREQ synchronizer.
module dma_priority_arbiter
    import dma_priority_arbiter_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 masterClear,
    dma_priority_arbiter_if.slave bus
);
    logic [NUM_CH-1:0] sample_s;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] eff_s;
    logic [NUM_CH-1:0] valid_dreq_q, valid_dreq_d;
    logic [NUM_CH-1:0] dack_act_s;
    logic [CH_W-1:0]   low_pri_q, low_pri_d;
    logic [CH_W-1:0]   active_q, active_d;
    logic [CH_W-1:0]   pri_base_s;
    logic [CH_W-1:0]   win_s;
    logic              win_valid_s;
    arbState_t         state_q, state_d;

`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    // Metastability synchronizer on the raw DREQ pins
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (masterClear) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.DREQ;
            sync2_q <= sync1_q;
        end
    end

    assign sample_s = sync2_q;
`else
    assign sample_s = bus.DREQ;
`endif

    // Request sampling with polarity normalised to active-high
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dreq_q <= '0;
        end else if (masterClear) begin
            dreq_q <= '0;
        end else begin
            dreq_q <= sample_s ^ {NUM_CH{bus.dreqSenseLow}};
        end
    end

    // Software requests bypass the mask
    assign eff_s      = (dreq_q & ~bus.maskReg) | bus.swReq;
    assign pri_base_s = bus.cmdRotate ? low_pri_q : CH_W'(NUM_CH - 1);

    dma_priority_encoder u_enc (
        .eff_i     (eff_s),
        .low_pri_i (pri_base_s),
        .winner_o  (win_s),
        .valid_o   (win_valid_s)
    );

    // Arbitration state and grant registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ARB_IDLE;
            low_pri_q    <= CH_W'(NUM_CH - 1);
            active_q     <= '0;
            valid_dreq_q <= '0;
        end else if (masterClear) begin
            state_q      <= ARB_IDLE;
            low_pri_q    <= CH_W'(NUM_CH - 1);
            active_q     <= '0;
            valid_dreq_q <= '0;
        end else begin
            state_q      <= state_d;
            low_pri_q    <= low_pri_d;
            active_q     <= active_d;
            valid_dreq_q <= valid_dreq_d;
        end
    end

    // Next-state logic; serviceDone is only honoured in ARB_SERVICE
    always_comb begin
        state_d      = state_q;
        low_pri_d    = low_pri_q;
        active_d     = active_q;
        valid_dreq_d = valid_dreq_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.idleCycle && win_valid_s && !bus.cmdDisable) begin
                    state_d      = ARB_GRANT;
                    active_d     = win_s;
                    valid_dreq_d = onehot_f(win_s);
                end else begin
                    state_d      = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (bus.hlda) begin
                    state_d      = ARB_SERVICE;
                end else if (!eff_s[active_q]) begin
                    state_d      = ARB_IDLE;
                    valid_dreq_d = '0;
                end else begin
                    state_d      = ARB_GRANT;
                end
            end
            ARB_SERVICE: begin
                if (bus.serviceDone) begin
                    state_d      = ARB_RELEASE;
                    valid_dreq_d = '0;
                end else begin
                    state_d      = ARB_SERVICE;
                end
            end
            ARB_RELEASE: begin
                state_d      = ARB_IDLE;
                valid_dreq_d = '0;
                if (bus.cmdRotate) begin
                    low_pri_d = active_q;
                end else begin
                    low_pri_d = low_pri_q;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                valid_dreq_d = '0;
            end
        endcase
    end

    // Acknowledge only while servicing and the timing FSM asks for it
    always_comb begin
        dack_act_s = '0;
        if ((state_q == ARB_SERVICE) && bus.validDack) begin
            dack_act_s = onehot_f(active_q);
        end else begin
            dack_act_s = '0;
        end
    end

    assign bus.VALID_DREQ = valid_dreq_q;
    assign bus.activeCh   = active_q;
    assign bus.reqPending = |eff_s;
    assign bus.reqStatus  = dreq_q;
    assign bus.DACK       = dack_act_s ^ {NUM_CH{~bus.dackSenseHigh}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: vector table plus grant scoreboard.
module tb_dma_priority_arbiter;
    import dma_priority_arbiter_pkg::*;

`ifdef DMA_DREQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic CLK;
    logic RESET_N;
    logic masterClear;

    dma_priority_arbiter_if bus();

    dma_priority_arbiter dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .masterClear (masterClear),
        .bus         (bus)
    );

    typedef struct {
        logic [3:0] dreq;
        logic [3:0] sw;
        logic [3:0] mask;
        logic       sl;
        logic [3:0] exp_vd;
        logic [1:0] exp_ch;
        logic       exp_pend;
    } vec_t;

    typedef struct {
        logic [3:0] vd;
        logic [1:0] ch;
    } exp_t;

    exp_t       sb_q[$];
    vec_t       tv[9];
    logic [1:0] rot_order[5];
    int         checks   = 0;
    int         failures = 0;
    int         cyc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge CLK);
    endtask

    task automatic push_exp(input logic [3:0] vd, input logic [1:0] ch);
        exp_t e;
        e.vd = vd;
        e.ch = ch;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare(input string name);
        exp_t e;
        checks++;
        if (bus.VALID_DREQ == 4'b0000) begin
            failures++;
            $display("FAIL %s_grant: got no grant expected %0d pending", name, sb_q.size());
            sb_q.delete();
        end else if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_grant: got VALID_DREQ=%b expected none", name, bus.VALID_DREQ);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_vd"}, 32'(bus.VALID_DREQ), 32'(e.vd));
            chk({name, "_ch"}, 32'(bus.activeCh), 32'(e.ch));
        end
    endtask

    task automatic wait_grant(input string name, input int limit, output int c);
        c = 0;
        for (int k = 1; k <= limit; k++) begin
            step(1);
            if (bus.VALID_DREQ != 4'b0000) begin
                c = k;
                break;
            end
        end
        sb_compare(name);
    endtask

    task automatic soft_clear(input logic sl);
        masterClear      = 1'b1;
        bus.dreqSenseLow = sl;
        bus.DREQ         = {4{sl}};
        bus.swReq        = 4'b0000;
        bus.maskReg      = 4'b0000;
        bus.cmdRotate    = 1'b0;
        bus.cmdDisable   = 1'b0;
        bus.hlda         = 1'b0;
        bus.validDack    = 1'b0;
        bus.serviceDone  = 1'b0;
        step(1);
        masterClear      = 1'b0;
    endtask

    initial begin
        RESET_N           = 1'b0;
        masterClear       = 1'b0;
        bus.DREQ          = 4'b0000;
        bus.swReq         = 4'b0000;
        bus.maskReg       = 4'b0000;
        bus.cmdDisable    = 1'b0;
        bus.cmdRotate     = 1'b0;
        bus.dreqSenseLow  = 1'b0;
        bus.dackSenseHigh = 1'b0;
        bus.idleCycle     = 1'b1;
        bus.hlda          = 1'b0;
        bus.validDack     = 1'b0;
        bus.serviceDone   = 1'b0;

        tv[0] = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tv[1] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1};
        tv[2] = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tv[3] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0};
        tv[4] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
        tv[5] = '{4'b1100, 4'b0000, 4'b0100, 1'b0, 4'b1000, 2'd3, 1'b1};
        tv[6] = '{4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1};
        tv[7] = '{4'b0000, 4'b0100, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
        tv[8] = '{4'b1111, 4'b0000, 4'b1110, 1'b0, 4'b0001, 2'd0, 1'b1};
        rot_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset values
        step(2);
        chk("rst_valid", 32'(bus.VALID_DREQ), 32'h0);
        chk("rst_active", 32'(bus.activeCh), 32'h0);
        chk("rst_pending", 32'(bus.reqPending), 32'h0);
        chk("rst_status", 32'(bus.reqStatus), 32'h0);
        chk("rst_dack_low", 32'(bus.DACK), 32'hF);
        bus.dackSenseHigh = 1'b1;
        #1;
        chk("rst_dack_high", 32'(bus.DACK), 32'h0);
        bus.dackSenseHigh = 1'b0;
        RESET_N = 1'b1;
        step(1);

        // Table-driven single-grant vectors
        for (int i = 0; i < 9; i++) begin
            soft_clear(tv[i].sl);
            bus.DREQ    = tv[i].dreq;
            bus.swReq   = tv[i].sw;
            bus.maskReg = tv[i].mask;
            if (tv[i].exp_vd != 4'b0000) push_exp(tv[i].exp_vd, tv[i].exp_ch);
            step(LAT - 1);
            if (tv[i].sw == 4'b0000) chk($sformatf("vec%0d_early", i), 32'(bus.VALID_DREQ), 32'h0);
            step(1);
            if (tv[i].exp_vd != 4'b0000) begin
                sb_compare($sformatf("vec%0d", i));
            end else begin
                chk($sformatf("vec%0d_nogrant", i), 32'(bus.VALID_DREQ), 32'h0);
                chk($sformatf("vec%0d_active", i), 32'(bus.activeCh), 32'(tv[i].exp_ch));
            end
            chk($sformatf("vec%0d_pending", i), 32'(bus.reqPending), 32'(tv[i].exp_pend));
            chk($sformatf("vec%0d_status", i), 32'(bus.reqStatus), 32'(tv[i].dreq ^ {4{tv[i].sl}}));
        end

        // Rotating priority with all channels requesting
        soft_clear(1'b0);
        bus.cmdRotate = 1'b1;
        bus.DREQ      = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            push_exp(onehot_f(rot_order[r]), rot_order[r]);
            wait_grant($sformatf("rot%0d", r), 8, cyc);
            if (r > 0) chk($sformatf("rot%0d_regrant_lat", r), 32'(cyc), 32'd2);
            bus.hlda        = 1'b1;
            step(1);
            bus.hlda        = 1'b0;
            bus.serviceDone = 1'b1;
            step(1);
            bus.serviceDone = 1'b0;
            chk($sformatf("rot%0d_drop", r), 32'(bus.VALID_DREQ), 32'h0);
        end

        // Polarity, DACK, no preemption, polarity change mid-service
        soft_clear(1'b1);
        bus.DREQ = 4'b1011;
        push_exp(4'b0100, 2'd2);
        wait_grant("pol", 8, cyc);
        chk("pol_dack_grant", 32'(bus.DACK), 32'hF);
        bus.hlda = 1'b1;
        step(1);
        bus.hlda      = 1'b0;
        bus.validDack = 1'b1;
        #1;
        chk("pol_dack_svc", 32'(bus.DACK), 32'hB);
        bus.DREQ = 4'b1010;
        step(LAT);
        chk("pol_no_preempt", 32'(bus.VALID_DREQ), 32'h4);
        chk("pol_no_preempt_ch", 32'(bus.activeCh), 32'd2);
        bus.dackSenseHigh = 1'b1;
        step(1);
        chk("pol_dack_flip", 32'(bus.DACK), 32'h4);
        bus.dackSenseHigh = 1'b0;
        bus.serviceDone   = 1'b1;
        step(1);
        bus.serviceDone = 1'b0;
        chk("pol_dack_release", 32'(bus.DACK), 32'hF);
        chk("pol_valid_release", 32'(bus.VALID_DREQ), 32'h0);
        bus.validDack = 1'b0;

        // hlda and serviceDone together in ARB_GRANT: pulse ignored
        push_exp(4'b0001, 2'd0);
        wait_grant("simul", 8, cyc);
        bus.hlda        = 1'b1;
        bus.serviceDone = 1'b1;
        step(1);
        bus.hlda        = 1'b0;
        bus.serviceDone = 1'b0;
        step(1);
        chk("simul_hold", 32'(bus.VALID_DREQ), 32'h1);
        bus.serviceDone = 1'b1;
        step(1);
        bus.serviceDone = 1'b0;
        chk("simul_drop", 32'(bus.VALID_DREQ), 32'h0);

        // Withdrawn request: back to idle, no rotation
        soft_clear(1'b0);
        bus.cmdRotate = 1'b1;
        bus.DREQ      = 4'b0010;
        push_exp(4'b0010, 2'd1);
        wait_grant("wd", 8, cyc);
        bus.DREQ = 4'b0000;
        step(LAT);
        chk("wd_clear", 32'(bus.VALID_DREQ), 32'h0);
        chk("wd_pending", 32'(bus.reqPending), 32'h0);
        bus.DREQ = 4'b0110;
        push_exp(4'b0010, 2'd1);
        wait_grant("wd_norot", 8, cyc);

        // Asynchronous reset in the middle of service
        soft_clear(1'b0);
        bus.DREQ = 4'b0100;
        push_exp(4'b0100, 2'd2);
        wait_grant("rst_svc", 8, cyc);
        bus.hlda = 1'b1;
        step(1);
        bus.hlda      = 1'b0;
        bus.validDack = 1'b1;
        #1;
        chk("rst_svc_dack_pre", 32'(bus.DACK), 32'hB);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_svc_valid", 32'(bus.VALID_DREQ), 32'h0);
        chk("rst_svc_active", 32'(bus.activeCh), 32'h0);
        chk("rst_svc_pending", 32'(bus.reqPending), 32'h0);
        chk("rst_svc_status", 32'(bus.reqStatus), 32'h0);
        chk("rst_svc_dack", 32'(bus.DACK), 32'hF);
        bus.validDack = 1'b0;
        bus.DREQ      = 4'b0000;
        step(1);
        RESET_N = 1'b1;
        step(1);

        // cmdDisable blocks new grants until cleared
        bus.cmdDisable = 1'b1;
        bus.DREQ       = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk($sformatf("dis_block%0d", k), 32'(bus.VALID_DREQ), 32'h0);
        end
        bus.cmdDisable = 1'b0;
        push_exp(4'b0100, 2'd2);
        wait_grant("dis_grant", 2, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
